// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the five-stage MIPS core: opcode/funct
// encodings used for control-flow detection, the NOP word, vector addresses
// and the interrupt-injector state type.
package pipe_pkg;

    // Opcodes that redirect the PC (REGIMM covers bltz/bgez and friends).
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    // R-type functs that redirect the PC.
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    // Vector addresses selected by the PC stage.
    localparam logic [31:0] VEC_RESET = 32'h8000_0000;
    localparam logic [31:0] VEC_IRQ   = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC   = 32'h8000_0008;

    // PCSrc encoding the PC stage uses for the interrupt vector.
    localparam logic [2:0] PCSRC_IRQ = 3'b100;

    // Cycles a captured control-flow instruction keeps the take blocked:
    // it must clear decode and execute before its redirect is resolved.
    localparam logic [1:0] CF_SHADOW = 2'd2;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PENDING = 1'b1
    } irq_state_e;

    // True when the instruction can redirect the PC.
    function automatic logic is_ctrl_flow(input logic [5:0] opcode,
                                          input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        case (opcode)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: hit = 1'b1;
            6'h00: hit = (funct == FN_JR) || (funct == FN_JALR);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ifid_stage_if.sv
// Bundle of the IF/ID stage signals. The master side is the fetch/hazard
// logic around the stage; the slave side is the IF/ID register itself.
interface ifid_stage_if;

    logic        datahazard;
    logic        flush;
    logic [31:0] PC;
    logic [31:0] PCplus;
    logic [31:0] Instruction;
    logic        irq;

    logic        irq_take;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCplus;
    logic        IFID_valid;
    logic        IFID_irq;
    logic [31:0] IFID_EPC;

    modport master (
        output datahazard, flush, PC, PCplus, Instruction, irq,
        input  irq_take, IFID_Instruction, IFID_PCplus, IFID_valid,
               IFID_irq, IFID_EPC
    );

    modport slave (
        input  datahazard, flush, PC, PCplus, Instruction, irq,
        output irq_take, IFID_Instruction, IFID_PCplus, IFID_valid,
               IFID_irq, IFID_EPC
    );

endinterface

// File: rtl/irq_injector.sv
// External-interrupt injector: tracks a pending user-mode interrupt and
// fires irq_take only at a safe point with no control flow in the shadow.
module irq_injector
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_i,
    input  logic       pc_kernel_i,
    input  logic       datahazard_i,
    input  logic       flush_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       irq_take_o
);

    irq_state_e state_q;
    logic [1:0] cf_cnt_q;
    logic       cf_load;

    // Take is combinational so the PC mux can switch to the vector in the
    // same cycle; reset outranks it.
    assign irq_take_o = !reset && (state_q == IRQ_PENDING) && irq_i &&
                        !pc_kernel_i && (cf_cnt_q == 2'd0) &&
                        !datahazard_i && !flush_i;

    // A normal load of a branch/jump opens the control-flow shadow.
    assign cf_load = !flush_i && !datahazard_i && !irq_take_o &&
                     is_ctrl_flow(opcode_i, funct_i);

    // Interrupt FSM and control-flow shadow counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IRQ_IDLE;
            cf_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                IRQ_IDLE:    if (irq_i && !pc_kernel_i) state_q <= IRQ_PENDING;
                IRQ_PENDING: if (irq_take_o || !irq_i)  state_q <= IRQ_IDLE;
                default:     state_q <= IRQ_IDLE;
            endcase

            if (flush_i) begin
                cf_cnt_q <= 2'd0;
            end else if (!datahazard_i) begin
                if (cf_load)
                    cf_cnt_q <= CF_SHADOW;
                else if (cf_cnt_q != 2'd0)
                    cf_cnt_q <= cf_cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with stall, flush and interrupt-bubble injection.
// Optional feature macro: IFID_IRQ_EN builds the interrupt injector and the
// EPC register; without it irq is ignored and the irq outputs read 0.
module ifid_stage #(
    parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_WORD,
    parameter logic [31:0] RESET_PC = pipe_pkg::VEC_RESET
) (
    input  logic         clk,
    input  logic         reset,
    ifid_stage_if.slave  bus
);

    logic [31:0] instr_q,  instr_d;
    logic [31:0] pcplus_q, pcplus_d;
    logic        valid_q,  valid_d;
    logic        irq_q,    irq_d;
    logic        irq_take;

`ifdef IFID_IRQ_EN
    logic [31:0] epc_q;

    irq_injector u_irq_injector (
        .clk          (clk),
        .reset        (reset),
        .irq_i        (bus.irq),
        .pc_kernel_i  (bus.PC[31]),
        .datahazard_i (bus.datahazard),
        .flush_i      (bus.flush),
        .opcode_i     (bus.Instruction[31:26]),
        .funct_i      (bus.Instruction[5:0]),
        .irq_take_o   (irq_take)
    );

    // Capture the squashed fetch address as the return address at the take.
    always_ff @(posedge clk) begin
        if (reset)
            epc_q <= RESET_PC;
        else if (irq_take)
            epc_q <= bus.PC;
    end

    assign bus.IFID_EPC = epc_q;
`else
    logic unused_irq;

    assign irq_take     = 1'b0;
    assign bus.IFID_EPC = 32'h0;
    assign unused_irq   = ^{bus.irq, bus.PC};
`endif

    // Next-state selection: flush > stall > interrupt take > normal load.
    always_comb begin
        // NOTE: each _d starts from its _q so every path assigns it and no latch is inferred.
        instr_d  = instr_q;
        pcplus_d = pcplus_q;
        valid_d  = valid_q;
        irq_d    = irq_q;
        if (bus.flush) begin
            instr_d  = NOP_WORD;
            pcplus_d = bus.PCplus;
            valid_d  = 1'b0;
            irq_d    = 1'b0;
        end else if (bus.datahazard) begin
            // Load-use stall: everything holds.
        end else if (irq_take) begin
            instr_d  = NOP_WORD;
            pcplus_d = bus.PCplus;
            valid_d  = 1'b0;
            irq_d    = 1'b1;
        end else begin
            instr_d  = bus.Instruction;
            pcplus_d = bus.PCplus;
            valid_d  = 1'b1;
            irq_d    = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            instr_q  <= NOP_WORD;
            pcplus_q <= RESET_PC;
            valid_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            pcplus_q <= pcplus_d;
            valid_q  <= valid_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.irq_take         = irq_take;
    assign bus.IFID_Instruction = instr_q;
    assign bus.IFID_PCplus      = pcplus_q;
    assign bus.IFID_valid       = valid_q;
    assign bus.IFID_irq         = irq_q;

endmodule

// File: tb/tb_ifid_stage.sv
// Directed testbench for ifid_stage. Interrupt expectations follow the
// IFID_IRQ_EN build option.
module tb_ifid_stage;

`ifdef IFID_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    ifid_stage_if bus ();

    ifid_stage #(
        .NOP_WORD (32'h0000_0000),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        bus.PC          = pc;
        bus.PCplus      = pc + 32'd4;
        bus.Instruction = instr;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.datahazard = 1'b0;
        bus.flush      = 1'b0;
        bus.irq        = 1'b0;
        fetch(32'h0040_0000, 32'h8C08_0000);
        tick();
        tick();

        // Reset state
        check("rst_instr",  bus.IFID_Instruction, 32'h0);
        check("rst_pcplus", bus.IFID_PCplus, 32'h8000_0000);
        check("rst_valid",  bus.IFID_valid, 1'b0);
        check("rst_irq",    bus.IFID_irq, 1'b0);
        check("rst_epc",    bus.IFID_EPC, IRQ_EN ? 32'h8000_0000 : 32'h0);
        check("rst_take",   bus.irq_take, 1'b0);

        // Normal load
        reset = 1'b0;
        tick();
        check("ld_instr",  bus.IFID_Instruction, 32'h8C08_0000);
        check("ld_pcplus", bus.IFID_PCplus, 32'h0040_0004);
        check("ld_valid",  bus.IFID_valid, 1'b1);

        // Two-cycle stall with changing fetch data
        bus.datahazard = 1'b1;
        fetch(32'h0040_0004, 32'h8C09_0004);
        tick();
        check("stall1_instr",  bus.IFID_Instruction, 32'h8C08_0000);
        check("stall1_pcplus", bus.IFID_PCplus, 32'h0040_0004);
        fetch(32'h0040_0008, 32'h0109_5020);
        tick();
        check("stall2_instr",  bus.IFID_Instruction, 32'h8C08_0000);
        check("stall2_pcplus", bus.IFID_PCplus, 32'h0040_0004);
        bus.datahazard = 1'b0;
        tick();
        check("resume_instr",  bus.IFID_Instruction, 32'h0109_5020);
        check("resume_pcplus", bus.IFID_PCplus, 32'h0040_000C);

        // Flush, then flush together with a stall
        bus.flush = 1'b1;
        fetch(32'h0040_000C, 32'h1234_5678);
        tick();
        check("flush_instr",  bus.IFID_Instruction, 32'h0);
        check("flush_valid",  bus.IFID_valid, 1'b0);
        check("flush_pcplus", bus.IFID_PCplus, 32'h0040_0010);
        bus.datahazard = 1'b1;
        fetch(32'h0040_0010, 32'h2222_2222);
        tick();
        check("flstall_instr",  bus.IFID_Instruction, 32'h0);
        check("flstall_valid",  bus.IFID_valid, 1'b0);
        check("flstall_pcplus", bus.IFID_PCplus, 32'h0040_0014);
        bus.flush      = 1'b0;
        bus.datahazard = 1'b0;

        // Interrupt with no control flow in flight
        fetch(32'h0040_0010, 32'h0109_5020);
        bus.irq = 1'b1;
        #1;
        check("irq_idle_take", bus.irq_take, 1'b0);
        tick();
        check("irq_take_hi", bus.irq_take, IRQ_EN);
        tick();
        check("irq_mark",  bus.IFID_irq, IRQ_EN);
        check("irq_epc",   bus.IFID_EPC, IRQ_EN ? 32'h0040_0010 : 32'h0);
        check("irq_valid", bus.IFID_valid, IRQ_EN ? 1'b0 : 1'b1);
        check("irq_instr", bus.IFID_Instruction, IRQ_EN ? 32'h0 : 32'h0109_5020);
        fetch(32'h8000_0004, 32'h0000_0000);
        #1;
        check("irq_kernel_take", bus.irq_take, 1'b0);
        tick();
        check("irq_after_mark",  bus.IFID_irq, 1'b0);
        check("irq_after_valid", bus.IFID_valid, 1'b1);
        bus.irq = 1'b0;

        // Interrupt in the shadow of a beq, then flush on the take cycle
        fetch(32'h0040_0020, 32'h1000_0003);
        tick();
        check("beq_instr", bus.IFID_Instruction, 32'h1000_0003);
        bus.irq = 1'b1;
        fetch(32'h0040_0024, 32'h0000_0000);
        #1;
        check("beq_take0", bus.irq_take, 1'b0);
        tick();
        check("beq_take1", bus.irq_take, 1'b0);
        fetch(32'h0040_0028, 32'h0000_0000);
        tick();
        check("beq_take2", bus.irq_take, IRQ_EN);
        bus.flush = 1'b1;
        #1;
        check("flush_blocks_take", bus.irq_take, 1'b0);
        tick();
        check("flush_take_mark",  bus.IFID_irq, 1'b0);
        check("flush_take_valid", bus.IFID_valid, 1'b0);
        bus.flush = 1'b0;
        fetch(32'h0040_0034, 32'h0109_5020);
        #1;
        check("retry_take", bus.irq_take, IRQ_EN);
        tick();
        check("retry_mark", bus.IFID_irq, IRQ_EN);
        check("retry_epc",  bus.IFID_EPC, IRQ_EN ? 32'h0040_0034 : 32'h0);
        bus.irq = 1'b0;
        fetch(32'h8000_0004, 32'h0000_0000);
        tick();

        // Interrupt while in kernel space is ignored
        fetch(32'h8000_0100, 32'h0000_0000);
        bus.irq = 1'b1;
        tick();
        check("kern_take1", bus.irq_take, 1'b0);
        tick();
        check("kern_take2", bus.irq_take, 1'b0);
        check("kern_mark",  bus.IFID_irq, 1'b0);
        bus.irq = 1'b0;
        tick();

        // jr shadow, then irq dropping while pending
        fetch(32'h0040_0050, 32'h03E0_0008);
        tick();
        check("jr_instr", bus.IFID_Instruction, 32'h03E0_0008);
        bus.irq = 1'b1;
        fetch(32'h0040_0054, 32'h0000_0000);
        tick();
        check("jr_take1", bus.irq_take, 1'b0);
        tick();
        check("jr_take2", bus.irq_take, IRQ_EN);
        bus.irq = 1'b0;
        #1;
        check("drop_take", bus.irq_take, 1'b0);
        tick();
        bus.irq = 1'b1;
        #1;
        check("drop_idle_take", bus.irq_take, 1'b0);
        bus.irq = 1'b0;
        tick();

        // Reset while pending
        fetch(32'h0040_0040, 32'h0000_0000);
        bus.irq = 1'b1;
        tick();
        check("pend_take", bus.irq_take, IRQ_EN);
        reset = 1'b1;
        #1;
        check("rst_pend_take", bus.irq_take, 1'b0);
        tick();
        check("rst_pend_mark",   bus.IFID_irq, 1'b0);
        check("rst_pend_pcplus", bus.IFID_PCplus, 32'h8000_0000);
        reset = 1'b0;
        #1;
        check("rst_idle_take", bus.irq_take, 1'b0);
        tick();
        check("rst_after_mark",  bus.IFID_irq, 1'b0);
        check("rst_after_valid", bus.IFID_valid, 1'b1);
        bus.irq = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
# ifid_stage

IF/ID pipeline register for the five-stage MIPS pipeline, directly downstream of the program counter and instruction memory. Each cycle it captures the fetched instruction and PC+4 for decode, holding on a data-hazard stall and squashing to a bubble on a branch/jump flush. It also owns external-interrupt injection. When a user-mode interrupt arrives, it waits for a safe point clear of in-flight control flow, then makes the PC select the interrupt vector. At the same edge it loads an interrupt-marked bubble carrying the return address.

## Interface
- Parameters:
  - NOP_WORD, 32'h00000000, instruction word loaded as a bubble.
  - RESET_PC, 32'h80000000, reset value of IFID_PCplus and IFID_EPC.
- Ports:
  - clk  in  1  pipeline clock.
  - reset  in  1  synchronous reset, active-high.
  - datahazard  in  1  load-use stall; IF/ID holds.
  - flush  in  1  branch taken / jump resolved; IF/ID becomes a bubble.
  - PC  in  32  address of the instruction being fetched this cycle.
  - PCplus  in  32  PC+4 from the PC stage; bit 31 is the kernel bit.
  - Instruction  in  32  instruction memory read data for PC (combinational ROM).
  - irq  in  1  level-sensitive external interrupt request.
  - irq_take  out  1  combinational; when high, the PC stage must select PCSrc 3'b100 (0x80000004).
  - IFID_Instruction  out  32  registered instruction to decode.
  - IFID_PCplus  out  32  registered PC+4.
  - IFID_valid  out  1  0 for a bubble.
  - IFID_irq  out  1  1 marks the interrupt bubble; decode writes IFID_EPC into $26.
  - IFID_EPC  out  32  return address; meaningful only when IFID_irq=1.

## Operation
- Priority at each rising edge: reset > flush > datahazard > irq take > normal load.
- Normal load:
  - IFID_Instruction <= Instruction; IFID_PCplus <= PCplus; IFID_valid <= 1; IFID_irq <= 0.
- flush:
  - IFID_Instruction <= NOP_WORD; IFID_valid <= 0; IFID_irq <= 0.
  - IFID_PCplus <= PCplus.
- datahazard (no flush): all IF/ID registers hold.
- Control-flow shadow counter `cf_cnt` (2 bits):
  - Loaded with 2 when a normal load captures a control-flow instruction. These are: opcode 6'h01, 6'h02, 6'h03, 6'h04–6'h07; opcode 0 with funct 6'h08 or 6'h09.
  - Otherwise it decrements (saturating at 0) on every edge where datahazard=0.
  - flush clears it to 0.
- Interrupt FSM, states IDLE and PENDING:
  - IDLE -> PENDING when irq=1 and PC[31]=0.
  - PENDING -> IDLE when irq drops before being taken (no take).
  - Take condition: state PENDING, irq=1, PC[31]=0, cf_cnt=0, datahazard=0, flush=0.
  - irq_take is exactly the take condition, asserted combinationally.
  - At the take edge: IFID_Instruction <= NOP_WORD; IFID_valid <= 0; IFID_irq <= 1; IFID_EPC <= PC; state <= IDLE.
  - The squashed fetch at PC re-executes after eret.
- Re-entry is blocked because the PC is in kernel space (bit 31 = 1) after the take.
- irq asserted while PC[31]=1 is ignored until user mode is re-entered, if irq is still high then.
- Reset mid-PENDING returns the FSM to IDLE; no take occurs.

## Timing
- Latency: Instruction/PCplus appear on the IF/ID outputs one cycle after presentation.
- irq to irq_take: at least 1 cycle (the IDLE->PENDING edge), plus any cycles with cf_cnt≠0, stalls, or flushes.
- irq_take is valid before the same edge at which the PC updates and IFID_irq is set; the two happen together.
- Reset values:
  - IFID_Instruction = NOP_WORD; IFID_valid = 0; IFID_irq = 0.
  - IFID_PCplus = RESET_PC; IFID_EPC = RESET_PC.
  - cf_cnt = 0; state IDLE; irq_take = 0.
- flush and a take condition in the same cycle: flush wins, state stays PENDING, and the take is retried later.

## Configuration
- IFID_IRQ_EN defined: interrupt FSM, cf_cnt and the EPC register are built.
- IFID_IRQ_EN undefined:
  - irq is ignored; irq_take, IFID_irq and IFID_EPC are tied to 0.
  - The block is a plain stall/flush pipeline register.

## Structure
- Shared package `pipe_pkg`:
  - Constants: OP_REGIMM, OP_J, OP_JAL, OP_BEQ..OP_BGTZ, FN_JR, FN_JALR, NOP_WORD.
  - Vector addresses: 32'h80000000 (reset), 32'h80000004 (interrupt), 32'h80000008 (exception).
  - FSM state enum.
- One sub-module `irq_injector` holds the FSM, cf_cnt and the take logic; `ifid_stage` holds the pipeline registers.

## Test plan
- Reset, then PC=0x00400000, Instruction=0x8C080000 -> next cycle IFID_Instruction=0x8C080000, IFID_PCplus=0x00400004, IFID_valid=1.
- datahazard=1 for 2 cycles with changing Instruction -> IF/ID outputs unchanged for 2 cycles; the value resumes updating on release.
- flush=1 -> IFID_Instruction=0, IFID_valid=0; flush and datahazard together -> bubble.
- irq=1 at PC=0x00400010, no control flow in flight -> irq_take high 1 cycle later; next edge IFID_irq=1, IFID_EPC=0x00400010.
- irq arriving the cycle after a beq (0x10000003) loads -> irq_take held low while cf_cnt≠0 and asserts only when cf_cnt=0; flush coinciding with the take condition delays the take.
- irq=1 with PC=0x80000100 -> irq_take never asserts; reset asserted during PENDING -> state IDLE, irq_take=0.
